// File: rtl/mem_access_pkg.sv
// Shared types for the load/store unit: funct3 size codes, FSM states, bus widths.
// Also provides the access legality check used at request acceptance.
// Imported by mem_access, mem_align and mem_access_if.
package mem_access_pkg;

    localparam int REG_DATA_WIDTH = 32;
    localparam int BE_WIDTH       = REG_DATA_WIDTH / 8;

    typedef enum logic [2:0] {
        F3_B  = 3'b000,
        F3_H  = 3'b001,
        F3_W  = 3'b010,
        F3_BU = 3'b100,
        F3_HU = 3'b101
    } funct3_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    // An access is refused when both request lines are up, when the address is
    // not naturally aligned for its size, or when funct3 names no legal access
    // for the direction (unsigned variants exist only for loads).
    function automatic logic access_illegal(input logic       rd,
                                            input logic       wr,
                                            input logic [2:0] f3,
                                            input logic [1:0] addr_lo);
        logic bad;
        bad = rd & wr;
        case (f3)
            F3_B:    bad = bad;
            F3_BU:   bad = bad | wr;
            F3_H:    bad = bad | addr_lo[0];
            F3_HU:   bad = bad | wr | addr_lo[0];
            F3_W:    bad = bad | (addr_lo != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_access_if.sv
// Data-memory bus between the load/store unit (master) and memory (slave).
// Master holds req/we/addr/wdata/be stable until the one-cycle ack.
// Slave returns rdata alongside ack; no other backpressure exists.
interface mem_access_if;
    import mem_access_pkg::*;

    logic                      dmem_req;
    logic                      dmem_we;
    logic [REG_DATA_WIDTH-1:0] dmem_addr;
    logic [REG_DATA_WIDTH-1:0] dmem_wdata;
    logic [BE_WIDTH-1:0]       dmem_be;
    logic                      dmem_ack;
    logic [REG_DATA_WIDTH-1:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        input  dmem_ack, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        output dmem_ack, dmem_rdata
    );

endinterface

// File: rtl/mem_align.sv
// Lane steering: store data replication + byte enables, load byte/half extract + extend.
// Latency: purely combinational, zero cycles.
// Backpressure: none; outputs follow inputs.
// Ports: funct3/addr_lo select size and lane; store_data -> wdata/be; rdata -> load_data.
module mem_align
    import mem_access_pkg::*;
(
    input  logic [2:0]                funct3,
    input  logic [1:0]                addr_lo,
    input  logic [REG_DATA_WIDTH-1:0] store_data,
    input  logic [REG_DATA_WIDTH-1:0] rdata,
    output logic [REG_DATA_WIDTH-1:0] wdata,
    output logic [BE_WIDTH-1:0]       be,
    output logic [REG_DATA_WIDTH-1:0] load_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        wdata = store_data;
        be    = 4'b1111;
        // Size lives in funct3[1:0]; funct3[2] only selects sign handling.
        case (funct3[1:0])
            2'b00: begin
                wdata = {4{store_data[7:0]}};
                be    = 4'b0001 << addr_lo;
            end
            2'b01: begin
                wdata = {2{store_data[15:0]}};
                be    = addr_lo[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                wdata = store_data;
                be    = 4'b1111;
            end
        endcase
    end

    always_comb begin
        byte_sel  = rdata[7:0];
        half_sel  = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        load_data = rdata;
        case (addr_lo)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        case (funct3)
            F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   load_data = {24'h0, byte_sel};
            F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
            F3_HU:   load_data = {16'h0, half_sel};
            default: load_data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// MEM-stage load/store unit: one bus access per request, IDLE -> BUSY -> DONE.
// Latency: 3 cycles minimum (accept, ack, done pulse); BUSY aborts after TIMEOUT_CYCLES.
// Backpressure: stall held combinationally from accept until the done cycle.
// Ports: pipeline request (mem_read/mem_write/funct3/alu_result/store_data), dmem master
// bus, load_data/done/err registered results, stall combinational.
module mem_access
    import mem_access_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
)
(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      mem_read,
    input  logic                      mem_write,
    input  logic [2:0]                funct3,
    input  logic [REG_DATA_WIDTH-1:0] alu_result,
    input  logic [REG_DATA_WIDTH-1:0] store_data,
    mem_access_if.master              dmem,
    output logic [REG_DATA_WIDTH-1:0] load_data,
    output logic                      stall,
    output logic                      done,
    output logic                      err
);

    localparam int                CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    // Abort on the cycle the counter would reach TIMEOUT_CYCLES, i.e. after
    // exactly TIMEOUT_CYCLES BUSY cycles without ack.
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_e                    state;
    logic [CNT_W-1:0]          tmo_cnt;
    logic [2:0]                f3_q;
    logic [1:0]                lo_q;
    logic                      start;
    logic                      illegal;
    logic [2:0]                al_f3;
    logic [1:0]                al_lo;
    logic [REG_DATA_WIDTH-1:0] al_wdata;
    logic [BE_WIDTH-1:0]       al_be;
    logic [REG_DATA_WIDTH-1:0] al_load;

    assign start   = mem_read | mem_write;
    assign illegal = access_illegal(mem_read, mem_write, funct3, alu_result[1:0]);
    assign stall   = ((state == ST_IDLE) && start) || (state == ST_BUSY);

    // The aligner serves the store path from live inputs at accept time and the
    // load path from the latched size/lane while waiting for ack.
    assign al_f3 = (state == ST_IDLE) ? funct3 : f3_q;
    assign al_lo = (state == ST_IDLE) ? alu_result[1:0] : lo_q;

    mem_align u_align (
        .funct3     (al_f3),
        .addr_lo    (al_lo),
        .store_data (store_data),
        .rdata      (dmem.dmem_rdata),
        .wdata      (al_wdata),
        .be         (al_be),
        .load_data  (al_load)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= ST_IDLE;
            tmo_cnt         <= '0;
            f3_q            <= 3'b000;
            lo_q            <= 2'b00;
            dmem.dmem_req   <= 1'b0;
            dmem.dmem_we    <= 1'b0;
            dmem.dmem_addr  <= '0;
            dmem.dmem_wdata <= '0;
            dmem.dmem_be    <= '0;
            load_data       <= '0;
            done            <= 1'b0;
            err             <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    err  <= 1'b0;
                    if (start) begin
                        if (illegal) begin
                            state     <= ST_DONE;
                            done      <= 1'b1;
                            err       <= 1'b1;
                            load_data <= '0;
                        end else begin
                            state           <= ST_BUSY;
                            tmo_cnt         <= '0;
                            f3_q            <= funct3;
                            lo_q            <= alu_result[1:0];
                            dmem.dmem_req   <= 1'b1;
                            dmem.dmem_we    <= mem_write;
                            dmem.dmem_addr  <= {alu_result[REG_DATA_WIDTH-1:2], 2'b00};
                            dmem.dmem_be    <= al_be;
                            dmem.dmem_wdata <= al_wdata;
                        end
                    end
                end
                ST_BUSY: begin
                    // Ack has priority over the timeout on the same cycle.
                    if (dmem.dmem_ack) begin
                        dmem.dmem_req <= 1'b0;
                        if (!dmem.dmem_we) begin
                            load_data <= al_load;
                        end
                        state <= ST_DONE;
                        done  <= 1'b1;
                        err   <= 1'b0;
                    end else if (tmo_cnt == CNT_LAST) begin
                        dmem.dmem_req <= 1'b0;
                        load_data     <= '0;
                        state         <= ST_DONE;
                        done          <= 1'b1;
                        err           <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    err   <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access with a 4-cycle timeout.
// Each access is driven and observed cycle by cycle at the falling edge.
// Expected values are hand-computed constants.
module tb_mem_access;

    logic        clk;
    logic        rst_n;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  funct3;
    logic [31:0] alu_result;
    logic [31:0] store_data;
    logic [31:0] load_data;
    logic        stall;
    logic        done;
    logic        err;

    mem_access_if bus ();

    mem_access #(.TIMEOUT_CYCLES(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .funct3     (funct3),
        .alu_result (alu_result),
        .store_data (store_data),
        .dmem       (bus.master),
        .load_data  (load_data),
        .stall      (stall),
        .done       (done),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_run  = 0;
    int n_fail = 0;

    // Per-access observations
    int          r_stall, r_done, r_busy;
    logic        r_req_seen, r_we, r_err, r_unstable;
    logic [31:0] r_addr, r_wdata, r_load;
    logic [3:0]  r_be;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Drives one request and holds it until done; ack is returned on the
    // ack_on-th BUSY cycle (0 = never). Runs two extra cycles after done.
    task automatic do_access(input logic rd, input logic wr, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] sd,
                             input int ack_on, input logic [31:0] rdata);
        int after;
        @(negedge clk);
        mem_read = rd; mem_write = wr; funct3 = f3; alu_result = addr; store_data = sd;
        #1;
        r_stall = 0; r_done = 0; r_busy = 0; r_req_seen = 1'b0; r_unstable = 1'b0;
        r_we = 1'b0; r_err = 1'b0; r_addr = '0; r_wdata = '0; r_load = '0; r_be = '0;
        after = -1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (stall) r_stall++;
            if (bus.dmem_req) begin
                r_busy++;
                if (r_busy > 1 && (bus.dmem_addr !== r_addr || bus.dmem_be !== r_be ||
                                   bus.dmem_wdata !== r_wdata || bus.dmem_we !== r_we))
                    r_unstable = 1'b1;
                r_req_seen = 1'b1;
                r_addr = bus.dmem_addr; r_be = bus.dmem_be;
                r_wdata = bus.dmem_wdata; r_we = bus.dmem_we;
            end
            if (bus.dmem_req && r_busy == ack_on) begin
                bus.dmem_ack = 1'b1; bus.dmem_rdata = rdata;
            end else begin
                bus.dmem_ack = 1'b0; bus.dmem_rdata = 32'h0;
            end
            if (done) begin
                r_done++;
                r_err = err; r_load = load_data;
                mem_read = 1'b0; mem_write = 1'b0;
                if (after < 0) after = cyc;
            end
            if (after >= 0 && cyc >= after + 2) break;
            @(negedge clk); #1;
        end
        bus.dmem_ack = 1'b0;
        mem_read = 1'b0; mem_write = 1'b0;
        if (after < 0) begin
            n_run++; n_fail++;
            $error("FAIL access_timeout observed=no_done expected=done");
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int   late_done;
        logic late_req;
        rst_n = 1'b0; mem_read = 1'b0; mem_write = 1'b0; funct3 = 3'b000;
        alu_result = '0; store_data = '0;
        bus.dmem_ack = 1'b0; bus.dmem_rdata = '0;

        // Reset state
        @(posedge clk); @(negedge clk);
        chk("rst_req",   32'(bus.dmem_req), 32'd0);
        chk("rst_we",    32'(bus.dmem_we), 32'd0);
        chk("rst_be",    32'(bus.dmem_be), 32'd0);
        chk("rst_addr",  bus.dmem_addr, 32'd0);
        chk("rst_wdata", bus.dmem_wdata, 32'd0);
        chk("rst_load",  load_data, 32'd0);
        chk("rst_done",  32'(done), 32'd0);
        chk("rst_err",   32'(err), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        rst_n = 1'b1;

        // LW 0x100, ack on 4th BUSY cycle (3 cycles after req)
        do_access(1, 0, 3'b010, 32'h100, 32'h0, 4, 32'hDEADBEEF);
        chk("lw_addr",   r_addr, 32'h100);
        chk("lw_be",     32'(r_be), 32'hF);
        chk("lw_we",     32'(r_we), 32'd0);
        chk("lw_load",   r_load, 32'hDEADBEEF);
        chk("lw_stall",  32'(r_stall), 32'd5);
        chk("lw_done",   32'(r_done), 32'd1);
        chk("lw_err",    32'(r_err), 32'd0);
        chk("lw_busy",   32'(r_busy), 32'd4);
        chk("lw_stable", 32'(r_unstable), 32'd0);

        // Byte / half loads, immediate ack (minimum latency)
        do_access(1, 0, 3'b000, 32'h103, 32'h0, 1, 32'h80112233);
        chk("lb_load",  r_load, 32'hFFFFFF80);
        chk("lb_addr",  r_addr, 32'h100);
        chk("lb_stall", 32'(r_stall), 32'd2);
        chk("lb_err",   32'(r_err), 32'd0);
        do_access(1, 0, 3'b100, 32'h103, 32'h0, 1, 32'h80112233);
        chk("lbu_load", r_load, 32'h00000080);
        do_access(1, 0, 3'b001, 32'h102, 32'h0, 1, 32'h80112233);
        chk("lh_load",  r_load, 32'hFFFF8011);
        do_access(1, 0, 3'b101, 32'h100, 32'h0, 1, 32'h80112233);
        chk("lhu_load", r_load, 32'h00002233);

        // Stores
        do_access(0, 1, 3'b001, 32'h102, 32'h00001234, 2, 32'hFFFFFFFF);
        chk("sh_we",     32'(r_we), 32'd1);
        chk("sh_be",     32'(r_be), 32'hC);
        chk("sh_wdata",  r_wdata, 32'h12341234);
        chk("sh_addr",   r_addr, 32'h100);
        chk("sh_load",   r_load, 32'h00002233);
        chk("sh_err",    32'(r_err), 32'd0);
        chk("sh_stable", 32'(r_unstable), 32'd0);
        do_access(0, 1, 3'b000, 32'h101, 32'h000000AB, 1, 32'h0);
        chk("sb_be",    32'(r_be), 32'h2);
        chk("sb_wdata", r_wdata, 32'hABABABAB);
        do_access(0, 1, 3'b010, 32'h104, 32'hCAFEF00D, 1, 32'h0);
        chk("sw_be",    32'(r_be), 32'hF);
        chk("sw_wdata", r_wdata, 32'hCAFEF00D);
        chk("sw_addr",  r_addr, 32'h104);

        // Illegal requests: no bus activity, done after one cycle with err
        do_access(1, 0, 3'b010, 32'h101, 32'h0, 1, 32'h0);
        chk("lw_mis_req",   32'(r_req_seen), 32'd0);
        chk("lw_mis_err",   32'(r_err), 32'd1);
        chk("lw_mis_load",  r_load, 32'd0);
        chk("lw_mis_stall", 32'(r_stall), 32'd1);
        chk("lw_mis_done",  32'(r_done), 32'd1);
        do_access(1, 0, 3'b001, 32'h103, 32'h0, 1, 32'h0);
        chk("lh_mis_req", 32'(r_req_seen), 32'd0);
        chk("lh_mis_err", 32'(r_err), 32'd1);
        do_access(1, 1, 3'b010, 32'h100, 32'h0, 1, 32'h0);
        chk("rdwr_req", 32'(r_req_seen), 32'd0);
        chk("rdwr_err", 32'(r_err), 32'd1);
        do_access(0, 1, 3'b100, 32'h100, 32'h0, 1, 32'h0);
        chk("sbu_req", 32'(r_req_seen), 32'd0);
        chk("sbu_err", 32'(r_err), 32'd1);
        do_access(1, 0, 3'b011, 32'h100, 32'h0, 1, 32'h0);
        chk("ld011_err", 32'(r_err), 32'd1);

        // Timeout: no ack, then ack on the last allowed cycle
        do_access(1, 0, 3'b010, 32'h108, 32'h0, 1, 32'h11111111);
        chk("pre_tmo_load", r_load, 32'h11111111);
        do_access(1, 0, 3'b010, 32'h10C, 32'h0, 0, 32'h0);
        chk("tmo_busy", 32'(r_busy), 32'd4);
        chk("tmo_err",  32'(r_err), 32'd1);
        chk("tmo_load", r_load, 32'd0);
        chk("tmo_done", 32'(r_done), 32'd1);
        do_access(1, 0, 3'b010, 32'h10C, 32'h0, 4, 32'h12345678);
        chk("tmo_ack_busy", 32'(r_busy), 32'd4);
        chk("tmo_ack_err",  32'(r_err), 32'd0);
        chk("tmo_ack_load", r_load, 32'h12345678);

        // Reset in the middle of BUSY, then a late ack
        @(negedge clk);
        mem_read = 1'b1; funct3 = 3'b010; alu_result = 32'h200;
        @(negedge clk); #1;
        chk("rb_req_busy", 32'(bus.dmem_req), 32'd1);
        @(negedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("rb_req_rst",  32'(bus.dmem_req), 32'd0);
        chk("rb_load_rst", load_data, 32'd0);
        mem_read = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        late_done = 0; late_req = 1'b0;
        bus.dmem_ack = 1'b1; bus.dmem_rdata = 32'hBAD0BAD0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            bus.dmem_ack = 1'b0;
            if (done) late_done++;
            if (bus.dmem_req) late_req = 1'b1;
        end
        chk("rb_late_done", 32'(late_done), 32'd0);
        chk("rb_late_req",  32'(late_req), 32'd0);
        chk("rb_late_load", load_data, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
